apb_master: RTL

- APB requester (initiator) driving the two-slave APB segment.
- Accepts single read/write commands on a valid/ready command port and runs the IDLE→SETUP→ACCESS sequence.
- Honours PREADY wait states from the selected slave.
- Returns read data, or a timeout error, on a one-cycle response strobe.
- Sits between the bus-test sequencer/CPU-side logic and slave1/slave2.

---
 rtl/apb_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// apb_master : APB requester; runs one command per IDLE->SETUP->ACCESS, honours PREADY, times out.
// Revision   : 1.0
// =============================================================================
module apb_master #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  // A zero TIMEOUT still needs a 1-bit counter so the vector stays legal.
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic              sel_q,       sel_d;
  logic              psel1_q,     psel1_d;
  logic              psel2_q,     psel2_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

  logic              ready_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic              timeout_hit;

  assign ready_sel   = sel_q ? PREADY2 : PREADY1;
  assign rdata_sel   = sel_q ? PRDATA2 : PRDATA1;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid) begin
          sel_d    = cmd_sel;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel1_d  = ~cmd_sel;
          psel2_d  = cmd_sel;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (ready_sel) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : rdata_sel;
          state_d     = ST_IDLE;
        end else if (timeout_hit) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          // Saturate so a disabled timeout can wait forever without wrapping.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire
